// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter_if
//  Description : Bundle of the MEM-stage, IF-stage and RAM-side signals of
//                the shared data/instruction memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if;
    // MEM stage request
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    // IF stage request
    logic        if_req;
    logic [15:0] if_addr;
    // RAM side
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    // Responses and status
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic [15:0] if_instr;
    logic        if_done;
    logic        stall_mem;
    logic        stall_if;
    logic        err_rw;

    // Arbiter side
    modport slave (
        input  mem_mem_read, mem_mem_write, mem_addr, mem_wdata,
        input  if_req, if_addr, ram_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output mem_rdata, mem_done, if_instr, if_done,
        output stall_mem, stall_if, err_rw
    );

    // Requester / RAM side
    modport master (
        output mem_mem_read, mem_mem_write, mem_addr, mem_wdata,
        output if_req, if_addr, ram_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  mem_rdata, mem_done, if_instr, if_done,
        input  stall_mem, stall_if, err_rw
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_port_arbiter
//  Description : Shares one single-port 16-bit RAM between the MEM stage and
//                the IF stage. One access at a time, MEM priority with an
//                anti-starvation counter for IF, one-cycle done pulses and
//                pipeline stall generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave arb_bus
);

    localparam int c_WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int c_SCNT_W = $clog2(STARVE_MAX + 1);

    localparam logic [c_WCNT_W-1:0] c_WCNT_LOAD   = c_WCNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_SCNT_W-1:0] c_STARVE_FULL = c_SCNT_W'(STARVE_MAX);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    localparam logic c_GNT_MEM = 1'b0;
    localparam logic c_GNT_IF  = 1'b1;

    logic [1:0]          state_q,     state_d;
    logic [c_WCNT_W-1:0] wcnt_q,      wcnt_d;
    logic [c_SCNT_W-1:0] starve_q,    starve_d;
    logic                grant_q,     grant_d;
    logic                ram_en_q,    ram_en_d;
    logic                ram_we_q,    ram_we_d;
    logic [15:0]         ram_addr_q,  ram_addr_d;
    logic [15:0]         ram_wdata_q, ram_wdata_d;
    logic [15:0]         mem_rdata_q, mem_rdata_d;
    logic [15:0]         if_instr_q,  if_instr_d;
    logic                mem_done_q,  mem_done_d;
    logic                if_done_q,   if_done_d;
    logic                err_rw_q,    err_rw_d;

    logic w_mem_req;
    logic w_any_req;
    logic w_starved;
    logic w_if_win;
    logic w_capture;

    assign w_mem_req = arb_bus.mem_mem_read | arb_bus.mem_mem_write;
    assign w_any_req = w_mem_req | arb_bus.if_req;
    assign w_starved = (starve_q == c_STARVE_FULL);
    // IF only beats a concurrent MEM request once it has been starved long enough
    assign w_if_win  = arb_bus.if_req & (~w_mem_req | w_starved);
    // RAM data becomes valid WAIT_CYCLES cycles after the edge that sampled
    // ram_en, so it is taken at the end of the last of WAIT_CYCLES wait cycles
    assign w_capture = (state_q == c_S_WAIT) && (wcnt_q == '0);

    // State and output registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= c_S_IDLE;
            wcnt_q      <= '0;
            starve_q    <= '0;
            grant_q     <= c_GNT_MEM;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            mem_rdata_q <= '0;
            if_instr_q  <= '0;
            mem_done_q  <= 1'b0;
            if_done_q   <= 1'b0;
            err_rw_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            starve_q    <= starve_d;
            grant_q     <= grant_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_instr_q  <= if_instr_d;
            mem_done_q  <= mem_done_d;
            if_done_q   <= if_done_d;
            err_rw_q    <= err_rw_d;
        end
    end

    // Sequencing, wait counting and arbitration (grants only from IDLE)
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        starve_d = starve_q;
        grant_d  = grant_q;
        case (state_q)
            c_S_IDLE: begin
                if (w_any_req) begin
                    state_d = c_S_ISSUE;
                    grant_d = w_if_win ? c_GNT_IF : c_GNT_MEM;
                    if (w_if_win) begin
                        starve_d = '0;
                    end else if (arb_bus.if_req && !w_starved) begin
                        starve_d = starve_q + c_SCNT_W'(1);
                    end
                end
            end
            c_S_ISSUE: begin
                state_d = c_S_WAIT;
                wcnt_d  = c_WCNT_LOAD;
            end
            c_S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = c_S_RESP;
                end else begin
                    wcnt_d = wcnt_q - c_WCNT_W'(1);
                end
            end
            c_S_RESP: begin
                state_d = c_S_IDLE;
            end
            default: begin
                state_d = c_S_IDLE;
            end
        endcase
    end

    // Next values of the registered RAM strobes, read data and done pulses
    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        mem_rdata_d = mem_rdata_q;
        if_instr_d  = if_instr_q;
        mem_done_d  = 1'b0;
        if_done_d   = 1'b0;
        err_rw_d    = err_rw_q | (arb_bus.mem_mem_read & arb_bus.mem_mem_write);

        if ((state_q == c_S_IDLE) && w_any_req) begin
            ram_en_d = 1'b1;
            if (w_if_win) begin
                ram_we_d    = 1'b0;
                ram_addr_d  = arb_bus.if_addr;
                ram_wdata_d = '0;
            end else begin
                // read+write together is carried out as a store
                ram_we_d    = arb_bus.mem_mem_write;
                ram_addr_d  = arb_bus.mem_addr;
                ram_wdata_d = arb_bus.mem_wdata;
            end
        end

        if (w_capture) begin
            if (grant_q == c_GNT_IF) begin
                if_instr_d = arb_bus.ram_rdata;
                if_done_d  = 1'b1;
            end else begin
                mem_done_d = 1'b1;
                if (!ram_we_q) begin
                    mem_rdata_d = arb_bus.ram_rdata;
                end
            end
        end
    end

    assign arb_bus.ram_en    = ram_en_q;
    assign arb_bus.ram_we    = ram_we_q;
    assign arb_bus.ram_addr  = ram_addr_q;
    assign arb_bus.ram_wdata = ram_wdata_q;
    assign arb_bus.mem_rdata = mem_rdata_q;
    assign arb_bus.if_instr  = if_instr_q;
    assign arb_bus.mem_done  = mem_done_q;
    assign arb_bus.if_done   = if_done_q;
    assign arb_bus.err_rw    = err_rw_q;
    assign arb_bus.stall_mem = w_mem_req & ~mem_done_q;
    assign arb_bus.stall_if  = arb_bus.if_req & ~if_done_q;

endmodule
`default_nettype wire
